mem_lsu_ctrl: RTL

- Requester-side controller for the 4-lane 64-bit data RAM.
- Takes one load/store request at a time from the core (valid/ready), converts the byte address into a RAM word index and lane enables, and returns a single-cycle response.
- Lane map: lane1 = byte0, lane2 = byte1, lane3 = bytes2-3, lane4 = bytes4-7.
- Stores narrower than their covering lane use a read-modify-write (RMW) sequence.

---
 rtl/mem_lsu_ctrl_if.sv | 27 ++
 rtl/mem_lsu_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_ctrl_if.sv
// Core-side request/response bundle for the load/store controller.
// The master drives requests and consumes responses; the slave is the controller.
interface mem_lsu_ctrl_if #(
    parameter int unsigned DW = 64,
    parameter int unsigned AW = 27
);
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW+2:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/mem_lsu_ctrl.sv
// Single-outstanding load/store controller for a 4-lane 64-bit RAM
// (lane1 = byte0, lane2 = byte1, lane3 = bytes2-3, lane4 = bytes4-7).
module mem_lsu_ctrl #(
    parameter int unsigned DW = 64,
    parameter int unsigned AW = 27
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_lsu_ctrl_if.slave  req_if,
    output logic           ram1_en,
    output logic           ram2_en,
    output logic           ram3_en,
    output logic           ram4_en,
    output logic [AW-1:0]  ram_addr,
    output logic           ram_wr_en,
    output logic [DW-1:0]  ram_wdata,
    input  logic [DW-1:0]  ram_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_e;

    state_e        state_q, state_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;
    logic [2:0]    off_q, off_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] shifted_q, shifted_d;
    logic [DW-1:0] mask_q, mask_d;
    logic [3:0]    lanes_q, lanes_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [3:0]    ram_en_q, ram_en_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_wr_en_q, ram_wr_en_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;

    logic [2:0]    acc_off;
    logic [5:0]    acc_sh;
    logic          acc_misal;
    logic          acc_rmw;
    logic [3:0]    acc_lanes;
    logic [DW-1:0] acc_mask;
    logic [DW-1:0] rd_sh;
    logic [DW-1:0] ld_ext;

    assign acc_off = req_if.req_addr[2:0];
    assign acc_sh  = {acc_off, 3'b000};
    assign rd_sh   = ram_rdata >> {off_q, 3'b000};

    // Request decode: alignment, covering lanes, byte mask and RMW need.
    always_comb begin
        acc_misal = 1'b0;
        acc_rmw   = 1'b0;
        acc_lanes = 4'b0000;
        acc_mask  = '0;
        unique case (req_if.req_size)
            2'd0: begin
                acc_mask = DW'(64'hFF);
                acc_rmw  = (acc_off[2:1] != 2'b00);
                if (acc_off == 3'd0)      acc_lanes = 4'b0001;
                else if (acc_off == 3'd1) acc_lanes = 4'b0010;
                else if (!acc_off[2])     acc_lanes = 4'b0100;
                else                      acc_lanes = 4'b1000;
            end
            2'd1: begin
                acc_mask  = DW'(64'hFFFF);
                acc_misal = acc_off[0];
                acc_rmw   = acc_off[2];
                acc_lanes = acc_off[2] ? 4'b1000 : (acc_off[1] ? 4'b0100 : 4'b0011);
            end
            2'd2: begin
                acc_mask  = DW'(64'hFFFF_FFFF);
                acc_misal = (acc_off[1:0] != 2'b00);
                acc_lanes = acc_off[2] ? 4'b1000 : 4'b0111;
            end
            default: begin
                acc_mask  = '1;
                acc_misal = (acc_off != 3'd0);
                acc_lanes = 4'b1111;
            end
        endcase
        acc_mask = acc_mask << acc_sh;
    end

    // Load alignment and extension from the sampled RAM word.
    always_comb begin
        unique case (size_q)
            2'd0:    ld_ext = {{(DW-8){signed_q & rd_sh[7]}},   rd_sh[7:0]};
            2'd1:    ld_ext = {{(DW-16){signed_q & rd_sh[15]}}, rd_sh[15:0]};
            2'd2:    ld_ext = {{(DW-32){signed_q & rd_sh[31]}}, rd_sh[31:0]};
            default: ld_ext = rd_sh;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        signed_d    = signed_q;
        off_d       = off_q;
        wr_d        = wr_q;
        shifted_d   = shifted_q;
        mask_d      = mask_q;
        lanes_d     = lanes_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        ram_en_d    = 4'b0000;
        ram_wr_en_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_if.req_valid) begin
                    size_d     = req_if.req_size;
                    signed_d   = req_if.req_signed;
                    off_d      = acc_off;
                    wr_d       = req_if.req_wr;
                    shifted_d  = req_if.req_wdata << acc_sh;
                    mask_d     = acc_mask;
                    lanes_d    = acc_lanes;
                    ram_addr_d = req_if.req_addr[AW+2:3];
                    if (acc_misal) begin
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (!req_if.req_wr || acc_rmw) begin
                        state_d = RD;
                    end else begin
                        state_d     = WR;
                        ram_wr_en_d = 1'b1;
                        ram_en_d    = acc_lanes;
                        ram_wdata_d = req_if.req_wdata << acc_sh;
                    end
                end
            end
            RD: begin
                if (wr_q) begin
                    state_d     = WR;
                    ram_wr_en_d = 1'b1;
                    ram_en_d    = lanes_q;
                    ram_wdata_d = (ram_rdata & ~mask_q) | (shifted_q & mask_q);
                end else begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ld_ext;
                end
            end
            WR: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            off_q       <= 3'd0;
            wr_q        <= 1'b0;
            shifted_q   <= '0;
            mask_q      <= '0;
            lanes_q     <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            ram_en_q    <= 4'b0000;
            ram_addr_q  <= '0;
            ram_wr_en_q <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            off_q       <= off_d;
            wr_q        <= wr_d;
            shifted_q   <= shifted_d;
            mask_q      <= mask_d;
            lanes_q     <= lanes_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_en_q    <= ram_en_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_en_q <= ram_wr_en_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign req_if.req_ready = (state_q == IDLE) & rst_n;
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_err   = rsp_err_q;
    assign req_if.rsp_rdata = rsp_rdata_q;
    assign ram1_en          = ram_en_q[0];
    assign ram2_en          = ram_en_q[1];
    assign ram3_en          = ram_en_q[2];
    assign ram4_en          = ram_en_q[3];
    assign ram_addr         = ram_addr_q;
    assign ram_wr_en        = ram_wr_en_q;
    assign ram_wdata        = ram_wdata_q;

endmodule
